// File: rtl/constants.sv
// System address map constants shared by the interconnect decode and its slaves.
package constants;
  localparam logic [31:0] TIMER_START = 32'h0000_0040;
  localparam int unsigned TIMER_SIZE  = 5;
endpackage

// File: rtl/wishbone_timer.sv
// Wishbone timer/compare slave: prescaled up-counter, compare match flag and level IRQ.
// Define WISHBONE_TIMER_ONESHOT_EN to implement CTRL bit2 (stop on first match).
module wishbone_timer #(
  parameter logic [31:0] BASE_ADDRESS = constants::TIMER_START,
  parameter int unsigned NUM_REGS     = constants::TIMER_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [31:0] rel_addr;
  logic [2:0]  offset;
  logic        unused_addr_bits;
  logic        reg_valid;
  logic        req;
  logic        wr;
  logic        wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;

  logic        ctrl_en, ctrl_ie, ctrl_oneshot;
  logic [31:0] presc, cmp, count, pcnt;
  logic        match;
  logic        tick, match_hit;
  logic [31:0] rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) result[8*b +: 8] = new_val[8*b +: 8];
    end
    return result;
  endfunction

  assign rel_addr         = wb_adr_i - BASE_ADDRESS;
  assign offset           = rel_addr[2:0];
  assign unused_addr_bits = ^rel_addr[31:3];
  assign reg_valid        = ({29'd0, offset} < NUM_REGS);

  // A new request is only accepted while no ack is outstanding.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = req & wb_we_i & reg_valid;
  assign wr_ctrl   = wr & (offset == OFF_CTRL) & wb_sel_i[0];
  assign wr_presc  = wr & (offset == OFF_PRESC);
  assign wr_cmp    = wr & (offset == OFF_CMP);
  assign wr_count  = wr & (offset == OFF_COUNT);
  assign wr_status = wr & (offset == OFF_STATUS) & wb_sel_i[0];

  assign tick      = ctrl_en & (pcnt == presc);
  assign match_hit = tick & (count == cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : 32'd0;
    end
  end

  // Bus write to CTRL takes precedence over the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en <= wb_dat_i[0];
      ctrl_ie <= wb_dat_i[1];
    end else if (ctrl_oneshot & match_hit) begin
      ctrl_en <= 1'b0;
    end
  end

`ifdef WISHBONE_TIMER_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (rst)          ctrl_oneshot <= 1'b0;
    else if (wr_ctrl) ctrl_oneshot <= wb_dat_i[2];
  end
`else
  assign ctrl_oneshot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 32'd0;
      cmp   <= 32'd0;
    end else begin
      if (wr_presc) presc <= merge_bytes(presc, wb_dat_i, wb_sel_i);
      if (wr_cmp)   cmp   <= merge_bytes(cmp, wb_dat_i, wb_sel_i);
    end
  end

  // Prescaler restarts whenever the timer is stopped or its period is rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= 32'd0;
    end else if (~ctrl_en | wr_presc | (wr_ctrl & ~wb_dat_i[0]) | tick) begin
      pcnt <= 32'd0;
    end else begin
      pcnt <= pcnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= merge_bytes(count, wb_dat_i, wb_sel_i);
    end else if (tick) begin
      count <= (count == cmp) ? 32'd0 : count + 32'd1;
    end
  end

  // A match in the same cycle as a write-1-clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)                         match <= 1'b0;
    else if (match_hit)              match <= 1'b1;
    else if (wr_status & wb_dat_i[0]) match <= 1'b0;
  end

  always_comb begin
    rdata = 32'd0;
    if (reg_valid) begin
      case (offset)
        OFF_CTRL:   rdata = {29'd0, ctrl_oneshot, ctrl_ie, ctrl_en};
        OFF_PRESC:  rdata = presc;
        OFF_CMP:    rdata = cmp;
        OFF_COUNT:  rdata = count;
        OFF_STATUS: rdata = {31'd0, match};
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign irq_o = match & ctrl_ie;

endmodule

// File: tb/tb_wishbone_timer.sv
// Directed self-checking bench for wishbone_timer; read results flow through a scoreboard queue.
// Expectations follow WISHBONE_TIMER_ONESHOT_EN when it is defined for the build.
module tb_wishbone_timer;

  localparam logic [31:0] BASE = constants::TIMER_START;
  localparam logic [2:0] CTRL = 3'd0, PRESC = 3'd1, CMP = 3'd2, COUNT = 3'd3, STATUS = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];

  wishbone_timer dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One transaction: strobe before edge X, ack checked after X, ack drop checked after X+1.
  task automatic apply_stimulus(input logic write, input logic [2:0] off, input logic [31:0] data,
                                input logic [3:0] lanes, input string tag);
    logic [31:0] expected;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = write;
    wb_adr_i = BASE + 32'(off);
    wb_sel_i = lanes;
    wb_dat_i = write ? data : 32'd0;
    if (!write) exp_q.push_back(data);
    @(posedge clk);
    #1;
    check_output({tag, " ack"}, {31'd0, wb_ack_o}, 32'd1);
    if (!write) begin
      expected = exp_q.pop_front();
      check_output({tag, " data"}, wb_dat_o, expected);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check_output({tag, " ack drop"}, {31'd0, wb_ack_o}, 32'd0);
    if (!write) check_output({tag, " data idle"}, wb_dat_o, 32'd0);
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] lanes, input string tag);
    apply_stimulus(1'b1, off, data, lanes, tag);
  endtask

  task automatic wb_read(input logic [2:0] off, input logic [31:0] expected, input string tag);
    apply_stimulus(1'b0, off, expected, 4'hF, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic oneshot_build;
`ifdef WISHBONE_TIMER_ONESHOT_EN
    oneshot_build = 1'b1;
`else
    oneshot_build = 1'b0;
`endif
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'd0; wb_sel_i = 4'h0; wb_dat_i = 32'd0;

    // Reset state and reads of every offset
    repeat (3) @(posedge clk);
    #1;
    check_output("reset ack", {31'd0, wb_ack_o}, 32'd0);
    check_output("reset dat", wb_dat_o, 32'd0);
    check_output("reset irq", {31'd0, irq_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wb_read(3'(i), 32'd0, $sformatf("reset read off%0d", i));

    // PRESC=0, CMP=3: count 1,2,3,0 then match; W is the CTRL write edge
    wb_write(PRESC, 32'd0, 4'hF, "wr presc0");
    wb_write(CMP, 32'd3, 4'hF, "wr cmp3");
    wb_write(CTRL, 32'h3, 4'hF, "wr ctrl en ie");
    wb_read(COUNT, 32'd1, "count at W+2");
    check_output("irq before match", {31'd0, irq_o}, 32'd0);
    wb_read(COUNT, 32'd3, "count at W+4");
    check_output("irq after match", {31'd0, irq_o}, 32'd1);
    wb_read(STATUS, 32'd1, "status match");
    wb_write(STATUS, 32'd1, 4'hF, "clear on match edge");
    check_output("irq held by match", {31'd0, irq_o}, 32'd1);
    wb_write(STATUS, 32'd1, 4'hF, "clear status");
    check_output("irq cleared", {31'd0, irq_o}, 32'd0);
    wb_write(CTRL, 32'h0, 4'hF, "stop timer");
    wb_read(STATUS, 32'd1, "status last match");
    wb_write(STATUS, 32'd1, 4'hF, "clear status 2");
    wb_read(STATUS, 32'd0, "status cleared");
    wb_read(COUNT, 32'd0, "count stopped at 0");

    // PRESC=4 near wrap: one tick per 5 clocks, E is the CTRL write edge
    wb_write(PRESC, 32'd4, 4'hF, "wr presc4");
    wb_write(CMP, 32'hFFFF_FFFF, 4'hF, "wr cmp max");
    wb_write(COUNT, 32'hFFFF_FFFE, 4'hF, "wr count");
    wb_write(CTRL, 32'h1, 4'hF, "wr ctrl en");
    wb_read(COUNT, 32'hFFFF_FFFE, "presc E+2");
    wb_read(COUNT, 32'hFFFF_FFFE, "presc E+4");
    wb_read(COUNT, 32'hFFFF_FFFF, "presc E+6");
    wb_read(COUNT, 32'hFFFF_FFFF, "presc E+8");
    wb_read(COUNT, 32'hFFFF_FFFF, "presc E+10");
    wb_read(COUNT, 32'h0000_0000, "presc wrap");
    wb_read(STATUS, 32'd1, "wrap match");
    check_output("irq masked by ie", {31'd0, irq_o}, 32'd0);
    wb_write(CTRL, 32'h0, 4'hF, "stop timer 2");
    wb_write(STATUS, 32'd1, 4'hF, "clear status 3");

    // Byte lanes
    wb_write(CMP, 32'h1234_5678, 4'b0101, "cmp lanes");
    wb_read(CMP, 32'hFF34_FF78, "cmp lanes rd");
    wb_write(CTRL, 32'h3, 4'b0000, "ctrl no lane");
    wb_read(CTRL, 32'h0, "ctrl no lane rd");

    // Bus write to COUNT collides with a tick (PRESC=1, tick at E+2)
    wb_write(CMP, 32'hFFFF_FFFF, 4'hF, "wr cmp max 2");
    wb_write(PRESC, 32'd1, 4'hF, "wr presc1");
    wb_write(COUNT, 32'hAABB_CC00, 4'hF, "wr count 2");
    wb_write(CTRL, 32'h1, 4'hF, "wr ctrl en 2");
    wb_write(COUNT, 32'h0000_0010, 4'b0001, "count on tick");
    wb_read(COUNT, 32'hAABB_CC10, "count write wins");
    wb_read(COUNT, 32'hAABB_CC11, "count next tick");
    wb_write(CTRL, 32'h0, 4'hF, "stop timer 3");

    // One-shot (or periodic without the feature); match lands at E+3
    wb_write(PRESC, 32'd0, 4'hF, "wr presc0 b");
    wb_write(COUNT, 32'd0, 4'hF, "wr count0");
    wb_write(CMP, 32'd2, 4'hF, "wr cmp2");
    wb_write(CTRL, 32'h5, 4'hF, "wr ctrl oneshot");
    idle(2);
    wb_read(CTRL, oneshot_build ? 32'h4 : 32'h1, "ctrl after match");
    wb_read(COUNT, oneshot_build ? 32'd0 : 32'd2, "count E+6");
    wb_read(COUNT, oneshot_build ? 32'd0 : 32'd1, "count E+8");
    wb_read(STATUS, 32'd1, "oneshot match");
    wb_write(CTRL, 32'h0, 4'hF, "stop timer 4");
    wb_write(STATUS, 32'd1, 4'hF, "clear status 4");
    wb_read(STATUS, 32'd0, "status cleared 2");

    // Reset lands on the edge that would acknowledge a write
    wb_write(CTRL, 32'h3, 4'hF, "ctrl before reset");
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = BASE + 32'(CMP); wb_sel_i = 4'hF; wb_dat_i = 32'hDEAD_BEEF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("no ack under reset", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wb_read(CMP, 32'd0, "cmp after reset");
    wb_read(CTRL, 32'd0, "ctrl after reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
